// File: rtl/mux_nto1_seq.sv
`default_nettype none
// ============================================================================
// Module   : mux_nto1_seq
// Brief    : N:1 channel selector with a one-deep registered valid/ready output
//            and an auto-scan mode that dwells DWELL samples per channel.
// Revision : 1.0 - initial release
// ============================================================================
module mux_nto1_seq #(
  parameter int N_CH  = 4,
  parameter int W     = 1,
  parameter int DWELL = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  input  logic                en,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                scan_wrap,
  output logic                sel_err
);

  localparam logic [SEL_W-1:0] c_last_ch   = SEL_W'(N_CH - 1);
  localparam logic [7:0]       c_last_dwell = 8'(DWELL - 1);

  logic [SEL_W-1:0] r_ptr, w_ptr_nxt, w_ptr_cur, w_src;
  logic [7:0]       r_dwell, w_dwell_nxt, w_dwell_cur;
  logic             r_mode_d, r_wrap_pend, w_wrap_pend_nxt, w_pend_cur;
  logic             w_cap, w_restart, w_sel_bad, w_scan_wrap_nxt;
  logic [W-1:0]     w_src_data;

  assign w_cap       = en & (~out_valid | out_ready);
  // Entering scan mode restarts the scan before this cycle's capture is taken.
  assign w_restart   = mode & ~r_mode_d;
  assign w_ptr_cur   = w_restart ? '0 : r_ptr;
  assign w_dwell_cur = w_restart ? '0 : r_dwell;
  assign w_pend_cur  = w_restart ? 1'b0 : r_wrap_pend;
  assign w_src       = mode ? w_ptr_cur : sel;

  generate
    if ((1 << SEL_W) == N_CH) begin : g_sel_full
      assign w_sel_bad = 1'b0;
    end else begin : g_sel_partial
      assign w_sel_bad = ~mode & ({1'b0, sel} >= (SEL_W + 1)'(N_CH));
    end
  endgenerate

  // Out-of-range selects match no channel and therefore yield zero data.
  always_comb begin
    w_src_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_src == SEL_W'(k)) begin
        w_src_data = in_data[k*W +: W];
      end
    end
  end

  // Scan state: register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_dwell     <= '0;
      r_mode_d    <= 1'b0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_dwell     <= w_dwell_nxt;
      r_mode_d    <= mode;
      r_wrap_pend <= w_wrap_pend_nxt;
    end
  end

  // Scan state: next state. The wrap pulse rides on the first channel-0
  // sample captured after the pointer wraps.
  always_comb begin
    w_ptr_nxt       = w_ptr_cur;
    w_dwell_nxt     = w_dwell_cur;
    w_wrap_pend_nxt = w_pend_cur;
    w_scan_wrap_nxt = 1'b0;
    if (w_cap && mode) begin
      w_scan_wrap_nxt = w_pend_cur;
      w_wrap_pend_nxt = 1'b0;
      if (w_dwell_cur == c_last_dwell) begin
        w_dwell_nxt = '0;
        if (w_ptr_cur == c_last_ch) begin
          w_ptr_nxt       = '0;
          w_wrap_pend_nxt = 1'b1;
        end else begin
          w_ptr_nxt = w_ptr_cur + SEL_W'(1);
        end
      end else begin
        w_dwell_nxt = w_dwell_cur + 8'd1;
      end
    end
  end

  // Output slot: refill on capture, empty on drain, frozen on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      scan_wrap <= w_scan_wrap_nxt;
      sel_err   <= w_cap & w_sel_bad;
      if (w_cap) begin
        out_data  <= w_src_data;
        out_ch    <= w_src;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
